// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: instruction memory,
// decode-side control (stall/redirect) and the IF/ID register outputs.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_target,
        output if_id_instr,
        output if_id_pc4,
        output if_id_valid
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_target,
        input  if_id_instr,
        input  if_id_pc4,
        input  if_id_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter plus IF/ID pipeline register.
// Define BRANCH_DELAY_SLOT_EN to keep the delay-slot instruction instead of squashing it.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    fetch_stage_if.master  bus
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    logic [31:0] w_pcPlus4;
    logic        w_redirect;
    logic [31:0] w_target;

    assign w_pcPlus4  = r_pc + 32'd4;
    assign w_redirect = bus.jump | bus.branch_taken;
    assign w_target   = bus.jump ? bus.jump_target : bus.branch_target;

    // Priority: reset > stall > redirect > sequential; a stalled redirect is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (!bus.stall) begin
            if (w_redirect) begin
                r_pc <= w_target;
`ifdef BRANCH_DELAY_SLOT_EN
                r_instr <= bus.imem_data;
                r_pc4   <= w_pcPlus4;
                r_valid <= 1'b1;
`else
                r_instr <= NOP_INSTR;
                r_pc4   <= 32'd0;
                r_valid <= 1'b0;
`endif
            end else begin
                r_pc    <= w_pcPlus4;
                r_instr <= bus.imem_data;
                r_pc4   <= w_pcPlus4;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.if_id_instr = r_instr;
    assign bus.if_id_pc4   = r_pc4;
    assign bus.if_id_valid = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues the hand-computed state
// expected after each edge and a negedge monitor pops and compares it.
module tb_fetch_stage;

    typedef struct {
        int          step;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } expect_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   stepNum;
    expect_t scoreQ[$];

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: three program words at 0..8, elsewhere a tag built from the address.
    function automatic logic [31:0] memRead(input logic [31:0] addr);
        case (addr)
            32'h0: memRead = 32'h2008_0001;
            32'h4: memRead = 32'h2009_0002;
            32'h8: memRead = 32'h200A_0003;
            default: memRead = 32'hC000_0000 | {24'h0, addr[7:0]};
        endcase
    endfunction

    assign bus.imem_data = memRead(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%08h expected=%08h", name, actual, expected);
        end
    endtask

    // Drive one cycle of control inputs and queue the state expected after the edge.
    task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] bt,
                                 input logic jmp, input logic [31:0] jt,
                                 input logic [31:0] ePc, input logic [31:0] eInstr,
                                 input logic [31:0] ePc4, input logic eValid);
        expect_t e;
        bus.stall         = stall;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.jump          = jmp;
        bus.jump_target   = jt;
        @(posedge clk);
        #1;
        stepNum++;
        e.step  = stepNum;
        e.pc    = ePc;
        e.instr = eInstr;
        e.pc4   = ePc4;
        e.valid = eValid;
        scoreQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (scoreQ.size() > 0) begin
            expect_t e;
            e = scoreQ.pop_front();
            checkOutput($sformatf("step%0d_pc", e.step),    bus.imem_addr,   e.pc);
            checkOutput($sformatf("step%0d_instr", e.step), bus.if_id_instr, e.instr);
            checkOutput($sformatf("step%0d_pc4", e.step),   bus.if_id_pc4,   e.pc4);
            checkOutput($sformatf("step%0d_valid", e.step), {31'd0, bus.if_id_valid}, {31'd0, e.valid});
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        stepNum = 0;
        reset   = 1'b0;
        bus.stall         = 1'bx;
        bus.branch_taken  = 1'bx;
        bus.branch_target = 32'h0;
        bus.jump          = 1'bx;
        bus.jump_target   = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("reset_pc",    bus.imem_addr,   32'h0);
        checkOutput("reset_instr", bus.if_id_instr, 32'h0);
        checkOutput("reset_pc4",   bus.if_id_pc4,   32'h0);
        checkOutput("reset_valid", {31'd0, bus.if_id_valid}, 32'd0);
        reset = 1'b1;

        // Sequential fetch from RESET_PC.
        applyStimulus(0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1);
        applyStimulus(0, 0, 0, 0, 0, 32'h8, 32'h2009_0002, 32'h8, 1);
        // Three-cycle stall at pc = 8.
        applyStimulus(1, 0, 0, 0, 0, 32'h8, 32'h2009_0002, 32'h8, 1);
        applyStimulus(1, 0, 0, 0, 0, 32'h8, 32'h2009_0002, 32'h8, 1);
        applyStimulus(1, 0, 0, 0, 0, 32'h8, 32'h2009_0002, 32'h8, 1);
        applyStimulus(0, 0, 0, 0, 0, 32'hC, 32'h200A_0003, 32'hC, 1);
        applyStimulus(0, 0, 0, 0, 0, 32'h10, 32'hC000_000C, 32'h10, 1);
        // Taken branch to 0x40 from pc = 0x10.
`ifdef BRANCH_DELAY_SLOT_EN
        applyStimulus(0, 1, 32'h40, 0, 0, 32'h40, 32'hC000_0010, 32'h14, 1);
`else
        applyStimulus(0, 1, 32'h40, 0, 0, 32'h40, 32'h0, 32'h0, 0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 32'h44, 32'hC000_0040, 32'h44, 1);
        // Jump and branch together: jump wins.
`ifdef BRANCH_DELAY_SLOT_EN
        applyStimulus(0, 1, 32'h40, 1, 32'h80, 32'h80, 32'hC000_0044, 32'h48, 1);
        applyStimulus(1, 0, 0, 1, 32'h100, 32'h80, 32'hC000_0044, 32'h48, 1);
`else
        applyStimulus(0, 1, 32'h40, 1, 32'h80, 32'h80, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 0, 1, 32'h100, 32'h80, 32'h0, 32'h0, 0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 32'h84, 32'hC000_0080, 32'h84, 1);
        // Jump to the top of the address space, then wrap.
`ifdef BRANCH_DELAY_SLOT_EN
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hC000_0084, 32'h88, 1);
`else
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'hC000_00FC, 32'h0, 1);

        for (int i = 0; i < 5 && scoreQ.size() > 0; i++) @(negedge clk);
        if (scoreQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain actual=%0d pending expected=0", scoreQ.size());
        end

        // Mid-cycle asynchronous reset while a redirect is requested.
        @(negedge clk);
        bus.jump        = 1'b1;
        bus.jump_target = 32'h200;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_pc",    bus.imem_addr,   32'h0);
        checkOutput("async_instr", bus.if_id_instr, 32'h0);
        checkOutput("async_valid", {31'd0, bus.if_id_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("async_hold_pc", bus.imem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU. It owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register consumed by the decode stage. Decode controls it in three ways: it stalls it from the hazard unit, redirects it on taken branches and jumps, and squashes the wrong-path instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on squash or reset (sll $0,$0,0).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low; clears all state immediately when low.
- imem_addr, output, 32, byte address to instruction memory; equals PC combinationally.
- imem_data, input, 32, instruction word returned combinationally for imem_addr.
- stall, input, 1, hold PC and IF/ID (load-use or other hazard).
- branch_taken, input, 1, taken branch resolved in decode this cycle.
- branch_target, input, 32, branch destination byte address.
- jump, input, 1, J/JAL/JR resolved in decode this cycle.
- jump_target, input, 32, jump destination byte address.
- if_id_instr, output, 32, registered instruction for decode.
- if_id_pc4, output, 32, registered PC+4 of that instruction.
- if_id_valid, output, 1, 1 = if_id_instr is a real instruction; 0 = bubble.

## Operation
- State: pc[31:0], if_id_instr, if_id_pc4, if_id_valid.
- Each edge selects exactly one action, with priority reset > stall > redirect > sequential.
- Reset (reset low, asynchronous):
  - pc = RESET_PC.
  - if_id_instr = NOP_INSTR, if_id_pc4 = 0, if_id_valid = 0.
- Stall:
  - pc and all IF/ID fields hold.
  - Any redirect asserted in the same cycle is ignored; decode re-asserts it once the stall clears.
- Redirect: the target is jump_target if jump = 1, else branch_target. Jump wins if both are asserted.
  - pc = target.
  - IF/ID handling depends on the delay-slot configuration.
- Sequential:
  - pc = pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
  - if_id_instr = imem_data, if_id_pc4 = pc + 4, if_id_valid = 1.
- Targets are used unaltered. Bits [1:0] are not checked; misaligned targets are the decode stage's responsibility.
- X on stall/branch_taken/jump while reset is low has no effect.

## Timing
- Fetch latency is 1 cycle: the word at PC appears on if_id_instr after the next rising edge.
- After reset deasserts:
  - first edge: if_id_instr = mem[RESET_PC], if_id_valid = 1.
  - pc = RESET_PC + 4.
- Redirect penalty:
  - BRANCH_DELAY_SLOT_EN undefined: 1 bubble.
  - BRANCH_DELAY_SLOT_EN defined: 0 bubbles.
- Outputs change only on a clk edge or asynchronous reset.
- A stall of N cycles freezes if_id outputs for exactly N edges.
- Reset asserted mid-stall or mid-redirect clears state immediately. The pending redirect is lost.

## Configuration
- BRANCH_DELAY_SLOT_EN, defined (MIPS delay slot):
  - On redirect, IF/ID loads imem_data (the instruction at the old pc) with valid = 1 and pc4 = old pc + 4.
  - The delay-slot instruction executes.
- BRANCH_DELAY_SLOT_EN, undefined (squash):
  - On redirect, IF/ID loads NOP_INSTR with valid = 0 and if_id_pc4 = 0.
  - The wrong-path instruction never reaches decode.

## Test plan
- Reset/sequential fetch:
  - Stimulus: memory words 0x20080001, 0x20090002, 0x200A0003 at 0, 4, 8; reset low for 1 cycle.
  - Response: during reset, if_id_valid = 0 and if_id_instr = 0. Over 3 edges, if_id_instr = 0x20080001/0x20090002/0x200A0003 and if_id_pc4 = 4/8/12.
- Stall:
  - Stimulus: stall high for 3 edges while pc = 8.
  - Response: imem_addr stays 8 and if_id is unchanged; the next edge loads mem[8].
- Branch (squash build):
  - Stimulus: branch_taken = 1, branch_target = 0x40, with pc = 0x10.
  - Response: next edge gives pc = 0x40, if_id_valid = 0, if_id_instr = 0. The following edge gives if_id_instr = mem[0x40], if_id_pc4 = 0x44.
- Branch (BRANCH_DELAY_SLOT_EN build):
  - Stimulus: same as the squash-build branch case.
  - Response: next edge gives if_id_instr = mem[0x10], valid = 1, pc = 0x40.
- Priority:
  - Stimulus 1: jump = 1 (target 0x80) and branch_taken = 1 (target 0x40) together. Response: pc = 0x80.
  - Stimulus 2: stall = 1 together with jump = 1. Response: pc unchanged.
- Wrap/async reset:
  - Stimulus: force pc = 0xFFFFFFFC, then sequential fetch.
  - Response: pc = 0 and if_id_pc4 = 0.
  - Then drop reset mid-cycle. Response: pc = RESET_PC and if_id_valid = 0 immediately, without waiting for a clk edge.
